// File: rtl/ts19a64_pkg.sv
// ts19a64_pkg: constants shared by the ts19a64 execution core.
//   DATA_W / MEM_DEPTH     datapath width and data-memory depth
//   OP_*                   opcode field values (10-bit I-type, 11-bit R/D-type)
//   FSL_*                  ALU function-select codes
package ts19a64_pkg;
  localparam int DATA_W    = 64;
  localparam int MEM_DEPTH = 32;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;

  localparam logic [4:0] FSL_AND  = 5'b00000;
  localparam logic [4:0] FSL_ORR  = 5'b00001;
  localparam logic [4:0] FSL_ADD  = 5'b00010;
  localparam logic [4:0] FSL_SUB  = 5'b00110;
  localparam logic [4:0] FSL_PASS = 5'b00111;
endpackage

// File: rtl/ts19a64_alu.sv
// ts19a64_alu: combinational 64-bit ALU with {V,C,N,Z} flags.
//   a, b    operands
//   fsl     function select (AND/ORR/ADD/SUB, anything else passes b)
//   y       result
//   status  {V,C,N,Z}; C and V are only meaningful for ADD/SUB, else 0
module ts19a64_alu
  import ts19a64_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        fsl,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        status
);
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] bx;
  logic              sub, arith, c, v;

  always_comb begin
    sub   = (fsl == FSL_SUB);
    arith = sub || (fsl == FSL_ADD);
    // Subtract as a + ~b + 1 so the carry-out is directly NOT borrow.
    bx    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{DATA_W{1'b0}}, sub};
    case (fsl)
      FSL_AND:          y = a & b;
      FSL_ORR:          y = a | b;
      FSL_ADD, FSL_SUB: y = sum[DATA_W-1:0];
      default:          y = b;
    endcase
    c = arith & sum[DATA_W];
    v = arith & (a[DATA_W-1] == bx[DATA_W-1]) & (y[DATA_W-1] != a[DATA_W-1]);
    status = {v, c, y[DATA_W-1], (y == '0)};
  end
endmodule

// File: rtl/ts19a64_core.sv
// ts19a64_core: single-cycle LEGv8-style core; executes Inst on every CLK edge.
//   CLK, Reset      clock, synchronous active-high reset (clears regs and memory)
//   Inst            instruction word, held externally
//   r0..r7          low 16 bits of X0..X7
//   TestPin         data-memory write enable (STUR decoded)
//   Status          ALU flags {V,C,N,Z}
//   K               extended immediate of the current instruction
//   DDL/AAL/BBL     destination / A-operand / B-operand register selects
//   FSL             ALU function select
module ts19a64_core
  import ts19a64_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic [31:0]       Inst,
  output logic [15:0]       r0,
  output logic [15:0]       r1,
  output logic [15:0]       r2,
  output logic [15:0]       r3,
  output logic [15:0]       r4,
  output logic [15:0]       r5,
  output logic [15:0]       r6,
  output logic [15:0]       r7,
  output logic              TestPin,
  output logic [3:0]        Status,
  output logic [DATA_W-1:0] K,
  output logic [4:0]        DDL,
  output logic [4:0]        AAL,
  output logic [4:0]        BBL,
  output logic [4:0]        FSL
);
  logic [31:0][DATA_W-1:0]        regs;
  logic [MEM_DEPTH-1:0][DATA_W-1:0] mem;

  logic              is_r, reg_we, mem_we, mem_rd;
  logic [DATA_W-1:0] ra, rb, alu_b, alu_y, wdata;
  logic [MEM_AW-1:0] addr;

  // Decoder
  always_comb begin
    is_r   = 1'b0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    mem_rd = 1'b0;
    FSL    = FSL_PASS;
    K      = '0;
    BBL    = 5'd0;
    if (Inst[31:22] == OP_ADDI || Inst[31:22] == OP_SUBI) begin
      K      = {{(DATA_W-12){1'b0}}, Inst[21:10]};
      FSL    = (Inst[31:22] == OP_SUBI) ? FSL_SUB : FSL_ADD;
      reg_we = 1'b1;
    end else begin
      case (Inst[31:21])
        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
          is_r   = 1'b1;
          reg_we = 1'b1;
          BBL    = Inst[20:16];
          case (Inst[31:21])
            OP_ADD:  FSL = FSL_ADD;
            OP_SUB:  FSL = FSL_SUB;
            OP_AND:  FSL = FSL_AND;
            default: FSL = FSL_ORR;
          endcase
        end
        OP_STUR: begin
          K      = {{(DATA_W-9){Inst[20]}}, Inst[20:12]};
          FSL    = FSL_ADD;
          BBL    = Inst[4:0];   // store data comes out of the B read port
          mem_we = 1'b1;
        end
        OP_LDUR: begin
          K      = {{(DATA_W-9){Inst[20]}}, Inst[20:12]};
          FSL    = FSL_ADD;
          reg_we = 1'b1;
          mem_rd = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign DDL     = Inst[4:0];
  assign AAL     = Inst[9:5];
  assign TestPin = mem_we;

  // XZR reads as zero on both ports, including as a base address.
  assign ra    = (AAL == 5'd31) ? '0 : regs[AAL];
  assign rb    = (BBL == 5'd31) ? '0 : regs[BBL];
  assign alu_b = is_r ? rb : K;

  ts19a64_alu u_alu (
    .a      (ra),
    .b      (alu_b),
    .fsl    (FSL),
    .y      (alu_y),
    .status (Status)
  );

  assign addr  = alu_y[MEM_AW-1:0];
  assign wdata = mem_rd ? mem[addr] : alu_y;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      regs <= '0;
      mem  <= '0;
    end else begin
      if (reg_we && DDL != 5'd31) regs[DDL] <= wdata;
      if (mem_we)                 mem[addr] <= rb;
    end
  end

  assign r0 = regs[0][15:0];
  assign r1 = regs[1][15:0];
  assign r2 = regs[2][15:0];
  assign r3 = regs[3][15:0];
  assign r4 = regs[4][15:0];
  assign r5 = regs[5][15:0];
  assign r6 = regs[6][15:0];
  assign r7 = regs[7][15:0];
endmodule

// File: tb/tb_ts19a64_core.sv
// tb_ts19a64_core: directed plus random instruction stream checked against an
// architectural model (register and memory arrays updated per instruction).
module tb_ts19a64_core;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Inst;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic        TestPin;
  logic [3:0]  Status;
  logic [63:0] K;
  logic [4:0]  DDL, AAL, BBL, FSL;

  ts19a64_core dut (
    .CLK(CLK), .Reset(Reset), .Inst(Inst),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .TestPin(TestPin), .Status(Status), .K(K),
    .DDL(DDL), .AAL(AAL), .BBL(BBL), .FSL(FSL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [63:0] m_reg [32];
  logic [63:0] m_mem [32];

  logic        e_tp, e_arith, e_rwe, e_mwe;
  logic [63:0] e_k, e_wval, e_mval;
  logic [4:0]  e_fsl, e_bbl, e_maddr;
  logic [3:0]  e_status;

  function automatic logic [63:0] rdx(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_reg[i];
  endfunction

  task automatic model_eval(input logic [31:0] in);
    logic [63:0] a, b, res;
    logic [64:0] u, s;
    logic        c, v;
    int          kind;   // 0 pass, 1 add, 2 sub, 3 and, 4 orr
    logic [63:0] imm12, imm9;
    imm12 = {52'd0, in[21:10]};
    imm9  = {{55{in[20]}}, in[20:12]};
    a = rdx(in[9:5]); b = 64'd0; kind = 0;
    e_tp = 0; e_k = 0; e_bbl = 0; e_fsl = 5'b00111; e_rwe = 0; e_mwe = 0;
    if (in[31:22] == 10'b1001000100)      begin e_k = imm12; kind = 1; e_rwe = 1; end
    else if (in[31:22] == 10'b1101000100) begin e_k = imm12; kind = 2; e_rwe = 1; end
    else if (in[31:21] == 11'b10001011000) begin kind = 1; e_rwe = 1; e_bbl = in[20:16]; end
    else if (in[31:21] == 11'b11001011000) begin kind = 2; e_rwe = 1; e_bbl = in[20:16]; end
    else if (in[31:21] == 11'b10001010000) begin kind = 3; e_rwe = 1; e_bbl = in[20:16]; end
    else if (in[31:21] == 11'b10101010000) begin kind = 4; e_rwe = 1; e_bbl = in[20:16]; end
    else if (in[31:21] == 11'b11111000000) begin e_k = imm9; kind = 1; e_mwe = 1; e_tp = 1; e_bbl = in[4:0]; end
    else if (in[31:21] == 11'b11111000010) begin e_k = imm9; kind = 1; e_rwe = 1; end
    b = (e_bbl != 0 && in[31:21] != 11'b11111000000) ? rdx(in[20:16]) : e_k;
    if (e_k == 0 && kind >= 1 && in[31:21] != 11'b11111000000 && in[31:21] != 11'b11111000010
        && in[31:22] != 10'b1001000100 && in[31:22] != 10'b1101000100)
      b = rdx(in[20:16]);
    c = 0; v = 0;
    case (kind)
      1: begin
        res = a + b;
        u = {1'b0, a} + {1'b0, b}; c = u[64];
        s = {a[63], a} + {b[63], b}; v = s[64] ^ s[63];
        e_fsl = 5'b00010;
      end
      2: begin
        res = a - b;
        c = (a >= b);
        s = {a[63], a} - {b[63], b}; v = s[64] ^ s[63];
        e_fsl = 5'b00110;
      end
      3: begin res = a & b; e_fsl = 5'b00000; end
      4: begin res = a | b; e_fsl = 5'b00001; end
      default: res = 64'd0;
    endcase
    e_arith  = (kind == 1 || kind == 2);
    e_status = {v, c, res[63], res == 64'd0};
    e_maddr  = res[4:0];
    e_mval   = rdx(in[4:0]);
    e_wval   = (in[31:21] == 11'b11111000010) ? m_mem[res[4:0]] : res;
  endtask

  task automatic model_edge(input logic rst, input logic [31:0] in);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_mem[i] = 0; end
    end else begin
      if (e_mwe) m_mem[e_maddr] = e_mval;
      if (e_rwe && in[4:0] != 5'd31) m_reg[in[4:0]] = e_wval;
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [15:0] got [8];
    got = '{r0, r1, r2, r3, r4, r5, r6, r7};
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s/r%0d", tag, i), {48'd0, got[i]}, {48'd0, m_reg[i][15:0]});
  endtask

  // One instruction: drive at negedge, check decode/flags, clock, check regs.
  task automatic step(input logic rst, input logic [31:0] in, input string tag);
    @(negedge CLK);
    Reset = rst; Inst = in;
    #1;
    model_eval(in);
    if (!rst) begin
      chk({tag, "/tp"},  {63'd0, TestPin}, {63'd0, e_tp});
      chk({tag, "/k"},   K, e_k);
      chk({tag, "/fsl"}, {59'd0, FSL}, {59'd0, e_fsl});
      chk({tag, "/ddl"}, {59'd0, DDL}, {59'd0, in[4:0]});
      chk({tag, "/aal"}, {59'd0, AAL}, {59'd0, in[9:5]});
      chk({tag, "/bbl"}, {59'd0, BBL}, {59'd0, e_bbl});
      // C is only defined for ADD/SUB
      chk({tag, "/st"}, {60'd0, e_arith ? Status : (Status & 4'b1011)},
          {60'd0, e_arith ? e_status : (e_status & 4'b1011)});
    end
    @(posedge CLK);
    model_edge(rst, in);
    #1;
    chk_regs(tag);
  endtask

  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [4:0] rsel();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    Reset = 1'b1; Inst = 32'd0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_mem[i] = 0; end

    // Reset 2 cycles, then idle no-op
    step(1'b1, 32'd0, "rst0");
    step(1'b1, 32'd0, "rst1");
    step(1'b0, 32'd0, "nop");
    chk("nop_fsl", {59'd0, FSL}, 64'd7);

    // ADDI X1,X0,5 held 10 edges
    for (int i = 0; i < 10; i++) step(1'b0, 32'h91001401, "addi5");
    chk("addi_r1", {48'd0, r1}, 64'd5);
    chk("addi_st", {60'd0, Status}, 64'd0);

    // STUR X1,[X31,1]
    step(1'b0, 32'hF80013E1, "stur");
    chk("stur_tp", {63'd0, TestPin}, 64'd1);
    // LDUR X2,[X31,1]
    step(1'b0, 32'hF84013E2, "ldur");
    chk("ldur_r2", {48'd0, r2}, 64'd5);
    // SUB X3,X1,X1 -> zero with C set
    step(1'b0, enc_r(11'b11001011000, 5'd1, 5'd1, 5'd3), "sub0");
    chk("sub_status", {60'd0, Status}, 64'b0101);
    // Write to XZR is discarded
    step(1'b0, enc_i(10'b1001000100, 12'd7, 5'd0, 5'd31), "xzr");
    // Held ADDI X1,X1,1 increments each edge
    for (int i = 0; i < 4; i++) step(1'b0, enc_i(10'b1001000100, 12'd1, 5'd1, 5'd1), "inc");
    chk("inc_r1", {48'd0, r1}, 64'd9);
    // Reset with an instruction present: reset wins
    step(1'b1, enc_i(10'b1001000100, 12'd3, 5'd0, 5'd4), "rstw");
    chk("rstw_r1", {48'd0, r1}, 64'd0);

    // Random stream
    for (int n = 0; n < 400; n++) begin
      logic [31:0] in;
      logic        rst;
      case ($urandom_range(0, 9))
        0, 1: in = enc_i(10'b1001000100, 12'($urandom), rsel(), rsel());
        2:    in = enc_i(10'b1101000100, 12'($urandom), rsel(), rsel());
        3:    in = enc_r(11'b10001011000, rsel(), rsel(), rsel());
        4:    in = enc_r(11'b11001011000, rsel(), rsel(), rsel());
        5:    in = enc_r(11'b10001010000, rsel(), rsel(), rsel());
        6:    in = enc_r(11'b10101010000, rsel(), rsel(), rsel());
        7:    in = enc_d(11'b11111000000, 9'($urandom), rsel(), rsel());
        8:    in = enc_d(11'b11111000010, 9'($urandom), rsel(), rsel());
        default: in = $urandom;
      endcase
      rst = ($urandom_range(0, 59) == 0);
      step(rst, in, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
